// File: rtl/neuron_accum_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// neuron_accum_ctrl_pkg
// Shared definitions for the neuron accumulation controller:
//   - default data / term-count widths
//   - controller state encoding
//   - sign-magnitude helpers (widen, finish = normalise + saturate + ReLU)
// The helpers work on a 64-bit carrier with the real widths passed as
// arguments, so the same functions serve any DW/CW instantiation. Width
// arguments are always elaboration-time constants, so each call reduces to
// plain wiring plus one magnitude compare.
// -----------------------------------------------------------------------------
package neuron_accum_ctrl_pkg;

  localparam int unsigned DW_DEF   = 8;
  localparam int unsigned CW_DEF   = 4;
  localparam int unsigned SM_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_FINISH = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // Low-order w-bit mask.
  function automatic logic [SM_MAX_W-1:0] sm_mask(input int unsigned w);
    return (64'(1) << w) - 64'(1);
  endfunction

  // {s, m} of width dw -> {s, zeros, m} of width acc_w.
  function automatic logic [SM_MAX_W-1:0] sm_widen(input logic [SM_MAX_W-1:0] v,
                                                   input int unsigned dw,
                                                   input int unsigned acc_w);
    logic [SM_MAX_W-1:0] sign_bit;
    sign_bit = (v >> (dw - 1)) & 64'(1);
    return (sign_bit << (acc_w - 1)) | (v & sm_mask(dw - 1));
  endfunction

  // Reduce an acc_w-bit sign-magnitude sum to dw bits: drop negative zero,
  // clamp the magnitude to the dw-bit maximum keeping the sign, then apply
  // the optional ReLU.
  function automatic logic [SM_MAX_W-1:0] sm_finish(input logic [SM_MAX_W-1:0] acc,
                                                    input int unsigned dw,
                                                    input int unsigned acc_w,
                                                    input logic relu);
    logic [SM_MAX_W-1:0] mag;
    logic                neg;
    mag = acc & sm_mask(acc_w - 1);
    neg = ((acc >> (acc_w - 1)) & 64'(1)) != 64'(0);
    if (mag == 64'(0)) neg = 1'b0;
    if (mag > sm_mask(dw - 1)) mag = sm_mask(dw - 1);
    if (relu && neg) begin
      mag = 64'(0);
      neg = 1'b0;
    end
    return ({63'(0), neg} << (dw - 1)) | mag;
  endfunction

endpackage

// File: rtl/neuron_accum_ctrl_smadd.sv
// -----------------------------------------------------------------------------
// neuron_accum_ctrl_smadd
// Combinational sign-magnitude adder.
//   a_i   in  W  sign-magnitude operand (bit W-1 = sign)
//   b_i   in  W  sign-magnitude operand
//   sum_o out W  sign-magnitude sum
// The caller guarantees the magnitude never overflows W-1 bits, so the carry
// out of the magnitude add is dropped. A zero result may carry either sign;
// the consumer normalises.
// -----------------------------------------------------------------------------
module neuron_accum_ctrl_smadd #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic         sa, sb;
  logic [W-2:0] ma, mb;
  logic [W-2:0] mag;
  logic         sign;

  assign sa = a_i[W-1];
  assign sb = b_i[W-1];
  assign ma = a_i[W-2:0];
  assign mb = b_i[W-2:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    mag  = '0;
    sign = 1'b0;
    if (sa == sb) begin
      mag  = ma + mb;
      sign = sa;
    end else if (ma >= mb) begin
      mag  = ma - mb;
      sign = sa;
    end else begin
      mag  = mb - ma;
      sign = sb;
    end
  end

  assign sum_o = {sign, mag};

endmodule

// File: rtl/neuron_accum_ctrl.sv
// -----------------------------------------------------------------------------
// neuron_accum_ctrl
// Sequences one shared sign-magnitude adder to compute bias + sum of `count`
// sign-magnitude terms, then saturates back to DW bits with optional ReLU.
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   start      in   1    begin a new sum (honoured in IDLE only)
//   count      in   CW   number of terms, latched on start
//   bias       in   DW   sign-magnitude bias, latched on start
//   relu_en    in   1    clamp negative results to zero, latched on start
//   in_data    in   DW   sign-magnitude term
//   in_valid   in   1    in_data valid
//   in_ready   out  1    term accepted this cycle (ACCUM only)
//   out_data   out  DW   registered result
//   out_valid  out  1    result valid, held until out_ready
//   out_ready  in   1    downstream accepts the result
//   busy       out  1    high outside IDLE
// -----------------------------------------------------------------------------
module neuron_accum_ctrl
  import neuron_accum_ctrl_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [DW-1:0] bias,
  input  logic          relu_en,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  // CW guard bits hold up to 2^CW full-scale magnitudes without wrapping.
  localparam int unsigned ACC_W = DW + CW;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               relu_q, relu_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W-1:0]   bias_wide;
  logic [ACC_W-1:0]   term_wide;
  logic [ACC_W-1:0]   sum;
  logic [DW-1:0]      result;

  assign bias_wide = ACC_W'(sm_widen(64'(bias), DW, ACC_W));
  assign term_wide = ACC_W'(sm_widen(64'(in_data), DW, ACC_W));
  assign result    = DW'(sm_finish(64'(acc_q), DW, ACC_W, relu_q));

  neuron_accum_ctrl_smadd #(
    .W (ACC_W)
  ) u_smadd (
    .a_i   (acc_q),
    .b_i   (term_wide),
    .sum_o (sum)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    relu_d      = relu_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = bias_wide;
          cnt_d   = count;
          relu_d  = relu_en;
          state_d = (count != '0) ? ST_ACCUM : ST_FINISH;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        out_data_d  = result;
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        // A start arriving together with out_ready is dropped: we are not in
        // IDLE yet when it is sampled.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
